buffered_data_port: RTL and testbench

BUFFERED_DATA_PORT -- requirements
Module: buffered_data_port

---
 rtl/pic_bus_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/buffered_data_port.sv | 125 ++++++++++++
 tb/tb_buffered_data_port.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared definitions for the buffered bus data port: default word width,
// the write-FIFO entry layout and the decoded bus strobe state.
package pic_bus_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // One write-FIFO entry: address bit captured alongside the data byte.
    typedef struct packed {
        logic                      a0;
        logic [DEFAULT_DATA_W-1:0] data;
    } fifo_entry_t;

    // Decoded state of the synchronised bus strobes.
    typedef enum logic [1:0] {
        BUS_IDLE     = 2'b00,
        BUS_WRITE    = 2'b01,
        BUS_READ     = 2'b10,
        BUS_CONFLICT = 2'b11
    } bus_state_t;

    function automatic bus_state_t decode_strobes(input logic wa, input logic ra);
        bus_state_t s;
        s = BUS_IDLE;
        if (wa && ra)
            s = BUS_CONFLICT;
        else if (wa)
            s = BUS_WRITE;
        else if (ra)
            s = BUS_READ;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head data, valid, full and overflow
// outputs. Pointers carry one extra bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_nxt;
    logic [AW:0]      rd_nxt;
    logic             do_pop;
    logic             do_push;
    logic             drop;
    logic [WIDTH-1:0] head_nxt;

    // Next-pointer and next-head computation; a push into a slot that is
    // about to become the head bypasses the memory.
    always_comb begin
        do_pop   = pop && valid;
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        wr_nxt   = wr_ptr + {{AW{1'b0}}, do_push};
        rd_nxt   = rd_ptr + {{AW{1'b0}}, do_pop};
        head_nxt = mem[rd_nxt[AW-1:0]];
        if (do_push && (rd_nxt[AW-1:0] == wr_ptr[AW-1:0]))
            head_nxt = din;
    end

    // Storage array, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointers and registered status/head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            valid    <= 1'b0;
            full     <= 1'b0;
            overflow <= 1'b0;
            dout     <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            valid    <= (wr_nxt != rd_nxt);
            full     <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            overflow <= drop;
            dout     <= head_nxt;
        end
    end

endmodule

// File: rtl/buffered_data_port.sv
// Bus-side data port: synchronises asynchronous bus strobes, captures
// writes into a FIFO on write end and latches read data on read start.
module buffered_data_port
    import pic_bus_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic              flag_from_control,
    input  logic [DATA_W-1:0] rd_data_int,
    output logic              wr_valid,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_a0,
    input  logic              wr_ready,
    output logic              fifo_full,
    output logic              overflow,
    output logic              proto_err
);
    // Synchroniser word: {settled, cs_n, rd_n, wr_n, a0, data}. The settled
    // bit shifts in a one after reset and marks the chain as flushed.
    localparam int SW = DATA_W + 5;
    localparam logic [SW-1:0] SYNC_IDLE = {1'b0, 3'b111, {(DATA_W + 1){1'b0}}};

    logic [SW-1:0]     sync_q [SYNC_STAGES];
    logic [SW-1:0]     sync_out;
    logic              settled;
    logic              wa;
    logic              ra;
    bus_state_t        state;
    bus_state_t        prev_state;
    logic              armed;
    logic              wr_pend;
    logic              push;
    logic [DATA_W:0]   cap;
    logic [DATA_W:0]   head;

    // Synchroniser chain on all bus inputs, idle (strobes high) after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= SYNC_IDLE;
        end else begin
            sync_q[0] <= {1'b1, cs_n, rd_n, wr_n, a0, data_in};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    // Strobe decode from synchronised copies only.
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        settled  = sync_out[SW-1];
        wa       = !sync_out[DATA_W+3] && !sync_out[DATA_W+1];
        ra       = !sync_out[DATA_W+3] && !sync_out[DATA_W+2];
        state    = decode_strobes(wa, ra);
        push     = wr_pend && !wa;
    end

    // Write capture and write-end tracking. A write is only armed once the
    // flushed bus has been seen idle, so a write in progress across reset
    // is discarded. A read/write conflict abandons the pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= BUS_IDLE;
            armed      <= 1'b0;
            wr_pend    <= 1'b0;
            cap        <= '0;
            proto_err  <= 1'b0;
        end else begin
            prev_state <= state;
            proto_err  <= (state == BUS_CONFLICT) && (prev_state != BUS_CONFLICT);
            if (settled && !wa)
                armed <= 1'b1;
            if (armed && state == BUS_WRITE) begin
                cap     <= sync_out[DATA_W:0];
                wr_pend <= 1'b1;
            end else if (state == BUS_CONFLICT || push) begin
                wr_pend <= 1'b0;
            end
        end
    end

    // Read-side output: track internal data under override, else latch on read start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            data_oe  <= 1'b0;
        end else begin
            data_oe <= (state == BUS_READ) || flag_from_control;
            if (flag_from_control)
                data_out <= rd_data_int;
            else if (state == BUS_READ && prev_state != BUS_READ && prev_state != BUS_CONFLICT)
                data_out <= rd_data_int;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (cap),
        .pop      (wr_ready),
        .valid    (wr_valid),
        .dout     (head),
        .full     (fifo_full),
        .overflow (overflow)
    );

    assign wr_a0   = head[DATA_W];
    assign wr_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_buffered_data_port.sv
// Directed plus randomized bench for buffered_data_port with a queue-based
// reference model of the write FIFO.
module tb_buffered_data_port;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs_n, rd_n, wr_n, a0;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              flag_from_control;
    logic [DATA_W-1:0] rd_data_int;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_a0;
    logic              wr_ready;
    logic              fifo_full;
    logic              overflow;
    logic              proto_err;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int perr_cnt = 0;
    int vld_cnt = 0;
    logic [DATA_W:0] model_q [$];

    buffered_data_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .flag_from_control(flag_from_control), .rd_data_int(rd_data_int),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_a0(wr_a0), .wr_ready(wr_ready),
        .fifo_full(fifo_full), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (overflow)  ovf_cnt++;
        if (proto_err) perr_cnt++;
        if (wr_valid)  vld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full bus write; the model decides whether it lands or is dropped.
    task automatic do_write(input logic a0v, input logic [DATA_W-1:0] d, input logic cs_first);
        int o;
        logic was_full;
        o = ovf_cnt;
        cs_n = 1'b0; wr_n = 1'b0; a0 = a0v; data_in = d;
        repeat (3) @(negedge clk);
        if (cs_first) begin
            cs_n = 1'b1;
            @(negedge clk);
            wr_n = 1'b1;
        end else begin
            wr_n = 1'b1; cs_n = 1'b1;
        end
        repeat (SYNC + 3) @(negedge clk);
        was_full = (model_q.size() >= DEPTH);
        if (!was_full) model_q.push_back({a0v, d});
        check("wr_overflow", ovf_cnt - o, was_full ? 1 : 0);
        check("wr_full", fifo_full, (model_q.size() == DEPTH) ? 1 : 0);
        check("wr_valid", wr_valid, (model_q.size() != 0) ? 1 : 0);
    endtask

    task automatic pop_one();
        check("pop_valid", wr_valid, 1);
        check("pop_head", {wr_a0, wr_data}, model_q[0]);
        void'(model_q.pop_front());
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        check("pop_after_valid", wr_valid, (model_q.size() != 0) ? 1 : 0);
    endtask

    initial begin
        int n, v0, p0;
        logic got;
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; data_in = '0;
        flag_from_control = 1'b0; rd_data_int = '0; wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_proto_err", proto_err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single write with consumer ready: latency and one-cycle valid.
        wr_ready = 1'b1;
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_in = 8'hA5;
        repeat (4) @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (wr_valid) got = 1'b1;
        end
        check("lat_seen", got, 1);
        check("lat_edges", n, SYNC + 1);
        check("lat_data", wr_data, 8'hA5);
        check("lat_a0", wr_a0, 1);
        @(negedge clk);
        check("lat_one_cycle", wr_valid, 0);
        wr_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Fill past capacity, then drain in order.
        for (int i = 1; i <= 5; i++) do_write(1'b0, DATA_W'(i), 1'b0);
        while (model_q.size() != 0) pop_one();

        // Read latch holds across internal data change.
        rd_data_int = 8'h3C;
        cs_n = 1'b0; rd_n = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        rd_data_int = 8'h77;
        repeat (3) @(negedge clk);
        check("rd_oe", data_oe, 1);
        check("rd_hold", data_out, 8'h3C);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        check("rd_oe_off", data_oe, 0);
        check("rd_hold_after", data_out, 8'h3C);
        cs_n = 1'b0; rd_n = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        check("rd_second", data_out, 8'h77);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (SYNC + 2) @(negedge clk);

        // Conflicting strobes.
        p0 = perr_cnt; v0 = vld_cnt;
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; data_in = 8'hEE;
        repeat (SYNC + 4) @(negedge clk);
        check("conf_oe", data_oe, 0);
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        check("conf_perr_pulses", perr_cnt - p0, 1);
        check("conf_no_push", vld_cnt - v0, 0);
        check("conf_empty", wr_valid, 0);

        // Control override forces drive and tracking.
        rd_data_int = 8'h99;
        flag_from_control = 1'b1;
        @(negedge clk);
        check("flag_oe", data_oe, 1);
        check("flag_data", data_out, 8'h99);
        rd_data_int = 8'h42;
        @(negedge clk);
        check("flag_track", data_out, 8'h42);
        flag_from_control = 1'b0;
        @(negedge clk);
        check("flag_oe_off", data_oe, 0);

        // Reset during a write discards it.
        v0 = vld_cnt;
        cs_n = 1'b0; wr_n = 1'b0; data_in = 8'h5A;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        check("rstw_no_valid", vld_cnt - v0, 0);
        check("rstw_empty", wr_valid, 0);
        check("rstw_not_full", fifo_full, 0);

        // Randomized writes (some ended by cs_n) interleaved with pops.
        for (int k = 0; k < 30; k++) begin
            if (($urandom_range(0, 2) == 0) && (model_q.size() != 0))
                pop_one();
            else
                do_write(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end
        while (model_q.size() != 0) pop_one();
        check("final_empty", wr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
